// File: rtl/crc16_rx_checker.sv
`default_nettype none
// ============================================================================
// Module : crc16_rx_checker
// Brief  : CRC-16 (poly 0x8005) frame checker. Strips the two trailing CRC
//          bytes, forwards the payload and reports per-frame status/counters.
// Rev    : 1.0 - initial release
// ============================================================================
module crc16_rx_checker #(
    parameter int MAX_LEN = 1024,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    output logic             s_ready,
    output logic             m_valid,
    output logic [7:0]       m_data,
    output logic             m_last,
    input  logic             m_ready,
    output logic             st_valid,
    output logic             st_crc_ok,
    output logic             st_len_err,
    output logic [CNT_W-1:0] st_len,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    localparam logic [0:0]       c_RECV   = 1'b0;
    localparam logic [0:0]       c_STATUS = 1'b1;
    localparam logic [15:0]      c_POLY   = 16'h8005;
    localparam logic [CNT_W-1:0] c_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_MAX    = {CNT_W{1'b1}};

    logic [0:0]       r_state;
    logic [1:0]       r_held;
    logic [7:0]       r_hold0;
    logic [7:0]       r_hold1;
    logic [15:0]      r_crc;
    logic [CNT_W-1:0] r_len;
    logic             r_m_valid;
    logic [7:0]       r_m_data;
    logic             r_m_last;
    logic             r_st_ok;
    logic             r_st_err;
    logic [CNT_W-1:0] r_st_len;
    logic [CNT_W-1:0] r_good;
    logic [CNT_W-1:0] r_bad;

    logic             w_accept;
    logic [15:0]      w_crc_next;
    logic [CNT_W-1:0] w_len_next;
    logic [31:0]      w_len_ext;
    logic             w_len_err;
    logic             w_crc_ok;

    function automatic logic [15:0] f_crc_byte(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ c_POLY;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    // The hold buffer may only be bypassed when the output slot can take a byte.
    assign s_ready    = !rst && (r_state == c_RECV) &&
                        ((r_held != 2'd2) || !r_m_valid || m_ready);
    assign w_accept   = s_valid && s_ready;
    assign w_crc_next = f_crc_byte(r_crc, s_data);
    assign w_len_next = (r_len == c_MAX) ? r_len : r_len + c_ONE;
    assign w_len_ext  = 32'(w_len_next);
    assign w_len_err  = (w_len_ext < 32'd2) || (w_len_ext > 32'(MAX_LEN));
    assign w_crc_ok   = (w_crc_next == 16'h0000) && !w_len_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_RECV;
            r_held    <= 2'd0;
            r_hold0   <= 8'h00;
            r_hold1   <= 8'h00;
            r_crc     <= 16'h0000;
            r_len     <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= 8'h00;
            r_m_last  <= 1'b0;
            r_st_ok   <= 1'b0;
            r_st_err  <= 1'b0;
            r_st_len  <= '0;
            r_good    <= '0;
            r_bad     <= '0;
        end else begin
            if (r_m_valid && m_ready) r_m_valid <= 1'b0;
            case (r_state)
                c_RECV: begin
                    if (w_accept) begin
                        r_crc <= w_crc_next;
                        r_len <= w_len_next;
                        if (r_held == 2'd2) begin
                            r_m_valid <= 1'b1;
                            r_m_data  <= r_hold0;
                            r_m_last  <= s_last;
                            r_hold0   <= r_hold1;
                            r_hold1   <= s_data;
                        end else begin
                            if (r_held == 2'd0) r_hold0 <= s_data;
                            else                r_hold1 <= s_data;
                            r_held <= r_held + 2'd1;
                        end
                        // Status is latched on the closing accept so it is
                        // presented during the single STATUS cycle.
                        if (s_last) begin
                            r_state  <= c_STATUS;
                            r_st_len <= w_len_next;
                            r_st_err <= w_len_err;
                            r_st_ok  <= w_crc_ok;
                            if (w_crc_ok) begin
                                if (r_good != c_MAX) r_good <= r_good + c_ONE;
                            end else begin
                                if (r_bad != c_MAX) r_bad <= r_bad + c_ONE;
                            end
                            r_crc  <= 16'h0000;
                            r_len  <= '0;
                            r_held <= 2'd0;
                        end
                    end
                end
                default: r_state <= c_RECV;
            endcase
        end
    end

    assign m_valid    = r_m_valid;
    assign m_data     = r_m_data;
    assign m_last     = r_m_last;
    assign st_valid   = (r_state == c_STATUS);
    assign st_crc_ok  = r_st_ok;
    assign st_len_err = r_st_err;
    assign st_len     = r_st_len;
    assign good_cnt   = r_good;
    assign bad_cnt    = r_bad;

endmodule
`default_nettype wire

// File: doc/crc16_rx_checker.md
Name: crc16_rx_checker

Overview:
- Receive-side companion of the byte-parallel CRC-16 generator: consumes a byte stream framed as payload followed by 2 CRC bytes (high byte first).
- Strips the CRC bytes and forwards the payload downstream.
- Checks the frame remainder and reports per-frame status plus saturating good/bad frame counters.
- CRC: poly 0x8005 (x^16+x^15+x^2+1), MSB-first, init 0x0000, no reflection, no final XOR; byte-parallel update, one byte per accepted beat.

Parameters:
- MAX_LEN, 1024, maximum total frame bytes (payload + 2 CRC); longer frames are flagged len_err.
- CNT_W, 16, width of frame_len and of the good/bad counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- s_valid  in  1  input byte valid.
- s_data  in  8  input byte.
- s_last  in  1  final byte of frame (second CRC byte).
- s_ready  out  1  input accept.
- m_valid  out  1  payload byte valid (registered).
- m_data  out  8  payload byte.
- m_last  out  1  final payload byte.
- m_ready  in  1  downstream accept.
- st_valid  out  1  one-cycle frame status pulse.
- st_crc_ok  out  1  remainder == 0 and no length error.
- st_len_err  out  1  frame < 2 bytes or > MAX_LEN bytes.
- st_len  out  CNT_W  total bytes received, saturating.
- good_cnt  out  CNT_W  frames with st_crc_ok=1, saturating.
- bad_cnt  out  CNT_W  frames with st_crc_ok=0, saturating.

Behaviour:
- Reset is synchronous active-high, one clock, single clock domain.
- Reset values: all outputs 0 (s_ready=0 during rst); crc=0, held=0, state RECV on the first cycle after rst deasserts.
- Reset mid-frame discards the frame: no status pulse, no counter update, m_valid dropped.
- Accept on s_valid&&s_ready; transfer on m_valid&&m_ready.
- Two-byte hold buffer (held = 0..2): the last two bytes of a frame are the CRC and are never forwarded.
- States: RECV, STATUS.
- RECV, s_ready = (held<2) || !m_valid || m_ready.
- RECV, accept with held<2: push byte, held++.
- RECV, accept with held==2: oldest held byte loads into the m_data register, m_valid=1 next cycle, m_last=s_last; new byte is pushed.
- On every accepted byte: crc <= next(crc, s_data); len <= len+1, saturating at all-ones.
- Accept with s_last=1 goes to STATUS. The byte count used for status includes this byte.
- STATUS (exactly 1 cycle):
  - s_ready=0, st_valid=1.
  - st_len = count.
  - st_len_err = (count<2) || (count>MAX_LEN).
  - st_crc_ok = (crc==0) && !st_len_err.
  - Increment good_cnt or bad_cnt, saturating at 2^CNT_W-1.
  - Clear crc, held and count; return to RECV.
- st_* outputs hold their values until the next STATUS cycle; st_valid is high only in STATUS.
- Latency: a payload byte appears on m_data 1 cycle after the accept that displaces it. Status appears 1 cycle after the s_last accept.
- Payload length 0 (frame of exactly 2 bytes) is legal: nothing forwarded, no m_last beat, status still reported.
- Frame of 1 byte: len_err, bad_cnt++, nothing forwarded.
- Oversize frame: payload still forwarded (no truncation), flagged at STATUS.
- Backpressure: while m_valid&&!m_ready with held==2, s_ready=0 and m_data/m_last stay stable.
- Simultaneous m_ready and new accept in the same cycle: the output register reloads with no bubble.
- s_data/s_last are ignored when s_valid=0.
- The m_last beat may still be pending downstream during STATUS; it stays valid until taken.

Test Plan:
- "123456789" (0x31..0x39), then 0xFE, 0xE8 (s_last), m_ready=1 -> m_data 0x31..0x39, m_last on 0x39, st_valid=1, st_crc_ok=1, st_len=11, good_cnt=1.
- Same frame with the final byte 0xE9 -> payload forwarded unchanged, st_crc_ok=0, bad_cnt=1, good_cnt unchanged.
- Frame 0x00,0x00 (s_last) -> no m_valid, st_crc_ok=1, st_len=2. Frame of single byte 0x55 -> st_len_err=1, bad_cnt++.
- Back-to-back frames with s_valid held high and m_ready toggling 1010... -> no lost or duplicated bytes, s_ready=0 only in STATUS or when the held buffer and output register are full.
- MAX_LEN=8, 10-byte frame with a correct CRC -> 8 payload bytes forwarded, st_len_err=1, st_crc_ok=0.
- rst asserted after 5 bytes of a frame, then a fresh good frame -> no status for the aborted frame, counters unchanged until the good frame gives good_cnt+1. Counter preset near all-ones -> saturates without wrap.
